// File: rtl/ttc_irq_sched6_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ttc_irq_sched_pkg6
// Brief    : Shared types and constants for the TTC interrupt scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package ttc_irq_sched_pkg6;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_POST   = 2'd3
   } state_t;

   typedef logic [1:0] tid_t;

   localparam logic [7:0]  c_INT_REG_BASE = 8'h54;
   localparam int unsigned c_REG_STRIDE   = 4;
   localparam tid_t        c_TID_NONE     = 2'd0;
   localparam tid_t        c_TID_LAST     = 2'd3;

   // Round-robin successor over timer IDs 1..3, wrapping 3 -> 1.
   function automatic tid_t rr_next(input tid_t id);
      return (id == c_TID_LAST) ? 2'd1 : id + 2'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ttc_irq_sched6_if.sv
`default_nettype none
// ============================================================================
// Module   : ttc_irq_sched6_if
// Brief    : APB master port towards the TTC plus the event handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface ttc_irq_sched6_if;
   import ttc_irq_sched_pkg6::*;

   logic        m_psel;
   logic        m_penable;
   logic        m_pwrite;
   logic [7:0]  m_paddr;
   logic [31:0] m_prdata;
   logic        evt_valid;
   logic        evt_ready;
   tid_t        evt_id;
   logic [5:0]  evt_status;

   modport master (
      output m_psel, m_penable, m_pwrite, m_paddr, evt_valid, evt_id, evt_status,
      input  m_prdata, evt_ready
   );

   modport slave (
      input  m_psel, m_penable, m_pwrite, m_paddr, evt_valid, evt_id, evt_status,
      output m_prdata, evt_ready
   );

endinterface
`default_nettype wire

// File: rtl/ttc_irq_sched6_arb.sv
`default_nettype none
// ============================================================================
// Module   : ttc_rr_arb6
// Brief    : 3-way combinational round-robin picker; grant 0 means no request.
// Revision : 1.0 - initial release
// ============================================================================
module ttc_rr_arb6
   import ttc_irq_sched_pkg6::*;
(
   input  logic [3:1] req,
   input  tid_t       last_grant,
   output tid_t       grant
);

   logic [3:0] w_req;
   tid_t       w_c1;
   tid_t       w_c2;
   tid_t       w_c3;

   assign w_req = {req, 1'b0};
   assign w_c1  = rr_next(last_grant);
   assign w_c2  = rr_next(w_c1);
   assign w_c3  = rr_next(w_c2);

   always_comb begin
      grant = c_TID_NONE;
      if (w_req[w_c1])      grant = w_c1;
      else if (w_req[w_c2]) grant = w_c2;
      else if (w_req[w_c3]) grant = w_c3;
   end

endmodule
`default_nettype wire

// File: rtl/ttc_irq_sched6.sv
`default_nettype none
// ============================================================================
// Module   : ttc_irq_sched6
// Brief    : Round-robin TTC interrupt scheduler: reads the read-to-clear
//            status of the granted timer over APB and posts it as an event.
//            Define TTC_IRQ_SCHED_STATS_EN for per-timer service counters.
// Revision : 1.0 - initial release
// ============================================================================
module ttc_irq_sched6
   import ttc_irq_sched_pkg6::*;
#(
   parameter logic [7:0] INT_REG_BASE = c_INT_REG_BASE
)(
   input  logic                    pclk6,
   input  logic                    n_p_reset6,
   input  logic                    sched_en,
   input  logic [3:1]              ttc_int,
   ttc_irq_sched6_if.master        bus,
   output logic                    busy
`ifdef TTC_IRQ_SCHED_STATS_EN
   ,
   output logic [7:0]              svc_cnt_1,
   output logic [7:0]              svc_cnt_2,
   output logic [7:0]              svc_cnt_3
`endif
);

   state_t     r_state;
   state_t     w_next;
   tid_t       r_grant;
   tid_t       r_last_grant;
   logic [5:0] r_status;
   logic       r_holdoff;
   tid_t       w_arb_grant;
   logic [7:0] w_paddr;
   logic       w_psel;
   logic       w_penable;
   logic [7:0] w_paddr_out;
   logic       w_evt_valid;
   tid_t       w_evt_id;
   logic [5:0] w_evt_status;
   logic       w_accept;
   logic       w_unused_prdata;

   ttc_rr_arb6 u_arb (
      .req        (ttc_int),
      .last_grant (r_last_grant),
      .grant      (w_arb_grant)
   );

   assign w_paddr         = INT_REG_BASE + 8'(c_REG_STRIDE) * {6'd0, r_grant - 2'd1};
   assign w_unused_prdata = ^bus.m_prdata[31:6];
   assign w_accept        = (r_state == ST_POST) && bus.evt_ready;

   always_ff @(posedge pclk6 or negedge n_p_reset6) begin
      if (!n_p_reset6) r_state <= ST_IDLE;
      else             r_state <= w_next;
   end

   // r_holdoff keeps IDLE from rearbitrating in the cycle right after a
   // spurious read, giving the TTC's registered interrupt lines time to drop.
   always_comb begin
      w_next       = r_state;
      w_psel       = 1'b0;
      w_penable    = 1'b0;
      w_paddr_out  = 8'h00;
      w_evt_valid  = 1'b0;
      w_evt_id     = c_TID_NONE;
      w_evt_status = 6'h00;
      case (r_state)
         ST_IDLE: begin
            if (sched_en && !r_holdoff && (w_arb_grant != c_TID_NONE))
               w_next = ST_SETUP;
         end
         ST_SETUP: begin
            w_psel      = 1'b1;
            w_paddr_out = w_paddr;
            w_next      = ST_ACCESS;
         end
         ST_ACCESS: begin
            w_psel      = 1'b1;
            w_penable   = 1'b1;
            w_paddr_out = w_paddr;
            w_next      = (bus.m_prdata[5:0] != 6'h00) ? ST_POST : ST_IDLE;
         end
         ST_POST: begin
            w_evt_valid  = 1'b1;
            w_evt_id     = r_grant;
            w_evt_status = r_status;
            if (bus.evt_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge pclk6 or negedge n_p_reset6) begin
      if (!n_p_reset6) begin
         r_grant      <= c_TID_NONE;
         r_last_grant <= c_TID_LAST;
         r_status     <= 6'h00;
         r_holdoff    <= 1'b0;
      end else begin
         r_holdoff <= (r_state == ST_ACCESS);
         if ((r_state == ST_IDLE) && (w_next == ST_SETUP))
            r_grant <= w_arb_grant;
         if (r_state == ST_ACCESS) begin
            r_status     <= bus.m_prdata[5:0];
            r_last_grant <= r_grant;
         end
      end
   end

   assign bus.m_psel     = w_psel;
   assign bus.m_penable  = w_penable;
   assign bus.m_pwrite   = 1'b0;
   assign bus.m_paddr    = w_paddr_out;
   assign bus.evt_valid  = w_evt_valid;
   assign bus.evt_id     = w_evt_id;
   assign bus.evt_status = w_evt_status;
   assign busy           = (r_state != ST_IDLE);

`ifdef TTC_IRQ_SCHED_STATS_EN
   logic [7:0] r_svc_cnt [1:3];

   for (genvar gi = 1; gi <= 3; gi++) begin : g_svc_cnt
      always_ff @(posedge pclk6 or negedge n_p_reset6) begin
         if (!n_p_reset6)
            r_svc_cnt[gi] <= 8'h00;
         else if (w_accept && (r_grant == tid_t'(gi)) && (r_svc_cnt[gi] != 8'hFF))
            r_svc_cnt[gi] <= r_svc_cnt[gi] + 8'h01;
      end
   end

   assign svc_cnt_1 = r_svc_cnt[1];
   assign svc_cnt_2 = r_svc_cnt[2];
   assign svc_cnt_3 = r_svc_cnt[3];
`else
   logic w_unused_accept;
   assign w_unused_accept = w_accept;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ttc_irq_sched6.sv
`default_nettype none
// ============================================================================
// Module   : tb_ttc_irq_sched6
// Brief    : Scoreboard bench for ttc_irq_sched6 (events and APB addresses).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ttc_irq_sched6;
   import ttc_irq_sched_pkg6::*;

   typedef struct packed {
      logic [1:0] id;
      logic [5:0] st;
   } evt_t;

   logic       pclk6 = 1'b0;
   logic       n_p_reset6;
   logic       sched_en;
   logic [3:1] ttc_int;
   logic       busy;
   logic [5:0] rd_val [1:3];
`ifdef TTC_IRQ_SCHED_STATS_EN
   logic [7:0] svc_cnt_1, svc_cnt_2, svc_cnt_3;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int n_acc    = 0;
   evt_t       exp_evt  [$];
   logic [7:0] exp_addr [$];
   evt_t       mon_evt;
   logic [7:0] mon_addr;

   ttc_irq_sched6_if bus ();

   ttc_irq_sched6 #(.INT_REG_BASE(8'h54)) dut (
      .pclk6      (pclk6),
      .n_p_reset6 (n_p_reset6),
      .sched_en   (sched_en),
      .ttc_int    (ttc_int),
      .bus        (bus),
      .busy       (busy)
`ifdef TTC_IRQ_SCHED_STATS_EN
      ,
      .svc_cnt_1  (svc_cnt_1),
      .svc_cnt_2  (svc_cnt_2),
      .svc_cnt_3  (svc_cnt_3)
`endif
   );

   always #5 pclk6 = ~pclk6;

   // TTC register model; upper bits are junk the scheduler must ignore.
   always_comb begin
      case (bus.m_paddr)
         8'h54:   bus.m_prdata = {26'h2AAAAAA, rd_val[1]};
         8'h58:   bus.m_prdata = {26'h2AAAAAA, rd_val[2]};
         8'h5C:   bus.m_prdata = {26'h2AAAAAA, rd_val[3]};
         default: bus.m_prdata = 32'hFFFF_FFFF;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   always @(negedge pclk6) begin
      if (n_p_reset6 && bus.evt_valid && bus.evt_ready) begin
         n_acc++;
         if (exp_evt.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL evt_unexpected: got id=%0d status=%0h, required none",
                     bus.evt_id, bus.evt_status);
         end else begin
            mon_evt = exp_evt.pop_front();
            check("evt_id", 32'(bus.evt_id), 32'(mon_evt.id));
            check("evt_status", 32'(bus.evt_status), 32'(mon_evt.st));
         end
      end
   end

   always @(negedge pclk6) begin
      if (n_p_reset6 && bus.m_psel && bus.m_penable) begin
         if (exp_addr.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL apb_unexpected: got paddr=%0h, required none", bus.m_paddr);
         end else begin
            mon_addr = exp_addr.pop_front();
            check("apb_paddr", 32'(bus.m_paddr), 32'(mon_addr));
            check("apb_pwrite", 32'(bus.m_pwrite), 32'd0);
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge pclk6);
         #1;
      end
   endtask

   task automatic wait_acc(input string name, input int target, input int bound);
      for (int i = 0; i < bound && n_acc < target; i++) step();
      check(name, 32'(n_acc >= target), 32'd1);
   endtask

   task automatic wait_access(input string name, input int bound);
      for (int i = 0; i < bound && !(bus.m_psel && bus.m_penable); i++) step();
      check(name, 32'(bus.m_psel && bus.m_penable), 32'd1);
   endtask

   task automatic push_evt(input logic [1:0] id, input logic [5:0] st, input logic [7:0] addr);
      exp_evt.push_back('{id: id, st: st});
      exp_addr.push_back(addr);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_p_reset6    = 1'b0;
      sched_en      = 1'b0;
      ttc_int       = 3'b000;
      bus.evt_ready = 1'b0;
      rd_val[1]     = 6'h00;
      rd_val[2]     = 6'h00;
      rd_val[3]     = 6'h00;
      step(3);

      check("rst_apb", {29'd0, bus.m_psel, bus.m_penable, bus.m_pwrite}, 32'd0);
      check("rst_paddr", 32'(bus.m_paddr), 32'd0);
      check("rst_evt", {22'd0, bus.evt_valid, bus.evt_id, bus.evt_status, busy}, 32'd0);
`ifdef TTC_IRQ_SCHED_STATS_EN
      check("rst_cnt", {8'd0, svc_cnt_1, svc_cnt_2, svc_cnt_3}, 32'd0);
`endif
      n_p_reset6 = 1'b1;
      step(2);

      // Single request from timer 2, then a stall in POST.
      rd_val[2] = 6'h04;
      push_evt(2'd2, 6'h04, 8'h58);
      ttc_int  = 3'b010;
      sched_en = 1'b1;
      step();
      check("t1_setup", {23'd0, bus.m_psel, bus.m_penable, bus.m_paddr}, {23'd0, 2'b10, 8'h58});
      ttc_int = 3'b001;
      step();
      check("t1_access", {23'd0, bus.m_psel, bus.m_penable, bus.m_paddr}, {23'd0, 2'b11, 8'h58});
      step();
      check("t1_latency", {23'd0, bus.evt_valid, bus.evt_id, bus.evt_status}, {23'd0, 1'b1, 2'd2, 6'h04});
      ttc_int = 3'b000;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t1_stall", {22'd0, bus.evt_valid, bus.evt_id, bus.evt_status, bus.m_psel},
               {22'd0, 1'b1, 2'd2, 6'h04, 1'b0});
      end
      bus.evt_ready = 1'b1;
      wait_acc("t1_done", 1, 5);
      bus.evt_ready = 1'b0;
      step(2);

      // Round robin from reset priority with all three lines held.
      n_p_reset6 = 1'b0;
      step(2);
      n_p_reset6 = 1'b1;
      rd_val[1] = 6'h01;
      rd_val[2] = 6'h02;
      rd_val[3] = 6'h03;
      push_evt(2'd1, 6'h01, 8'h54);
      push_evt(2'd2, 6'h02, 8'h58);
      push_evt(2'd3, 6'h03, 8'h5C);
      push_evt(2'd1, 6'h01, 8'h54);
      bus.evt_ready = 1'b1;
      ttc_int = 3'b111;
      wait_acc("t2_done", 5, 40);
      sched_en = 1'b0;
      step(4);
      check("t2_idle", 32'(busy), 32'd0);
      ttc_int  = 3'b000;
      sched_en = 1'b1;

      // Spurious read of timer 2, then timer 3 is served next.
      rd_val[2] = 6'h00;
      rd_val[3] = 6'h11;
      exp_addr.push_back(8'h58);
      push_evt(2'd3, 6'h11, 8'h5C);
      ttc_int = 3'b110;
      wait_access("t3_access", 10);
      step();
      check("t3_spurious", {30'd0, busy, bus.evt_valid}, 32'd0);
      step();
      check("t3_holdoff", 32'(busy), 32'd0);
      step();
      check("t3_next", {23'd0, bus.m_psel, bus.m_penable, bus.m_paddr}, {23'd0, 2'b10, 8'h5C});
      wait_acc("t3_done", 6, 10);
      ttc_int = 3'b000;
      step(2);

      // Reset during ACCESS of timer 2 after timer 1 was served.
      rd_val[1] = 6'h05;
      push_evt(2'd1, 6'h05, 8'h54);
      ttc_int = 3'b001;
      wait_acc("t4_pre", 7, 10);
      ttc_int = 3'b000;
      bus.evt_ready = 1'b0;
      rd_val[2] = 6'h07;
      step();
      ttc_int = 3'b010;
      wait_access("t4_access", 10);
      n_p_reset6 = 1'b0;
      #1;
      check("t4_abort", {28'd0, bus.m_psel, bus.m_penable, bus.evt_valid, busy}, 32'd0);
`ifdef TTC_IRQ_SCHED_STATS_EN
      check("t4_cnt_rst", {8'd0, svc_cnt_1, svc_cnt_2, svc_cnt_3}, 32'd0);
`endif
      step();
      rd_val[3] = 6'h22;
      push_evt(2'd1, 6'h05, 8'h54);
      ttc_int = 3'b101;
      bus.evt_ready = 1'b1;
      n_p_reset6 = 1'b1;
      wait_acc("t4_done", 8, 10);
      ttc_int = 3'b000;
      step(2);

`ifdef TTC_IRQ_SCHED_STATS_EN
      // Counter saturation on timer 3.
      rd_val[3] = 6'h01;
      for (int i = 0; i < 300; i++) push_evt(2'd3, 6'h01, 8'h5C);
      ttc_int = 3'b100;
      wait_acc("t5_done", 308, 1400);
      ttc_int = 3'b000;
      step(3);
      check("t5_cnt3", 32'(svc_cnt_3), 32'hFF);
      check("t5_cnt1", 32'(svc_cnt_1), 32'h01);
      check("t5_cnt2", 32'(svc_cnt_2), 32'h00);
`endif

      step(4);
      check("final_evt_queue", 32'(exp_evt.size()), 32'd0);
      check("final_addr_queue", 32'(exp_addr.size()), 32'd0);
      check("final_idle", 32'(busy), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
